// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one ALU between two requesters.
// Registers operands, captures the result, returns it with the requester ID.
module alu_share_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_func,
  input  logic             req0_control,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_func,
  input  logic             req1_control,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_func,
  output logic             alu_control,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  input  logic             rsp_ready
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_grant;
  logic   gnt0;
  logic   gnt1;

  // Grant and next-state; a tie goes to the port not granted last.
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rst) begin
          if (req0_valid && (!req1_valid || last_grant))
            gnt0 = 1'b1;
          else if (req1_valid)
            gnt1 = 1'b1;
        end
        if (gnt0 || gnt1)
          state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (rsp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid  = (state == RESP);

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Operand latch on grant, result capture in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_func    <= '0;
      alu_control <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      last_grant  <= 1'b1;
    end else begin
      if (gnt0 || gnt1) begin
        alu_a       <= gnt1 ? req1_a : req0_a;
        alu_b       <= gnt1 ? req1_b : req0_b;
        alu_func    <= gnt1 ? req1_func : req0_func;
        alu_control <= gnt1 ? req1_control : req0_control;
        rsp_id      <= gnt1;
        last_grant  <= gnt1;
      end
      if (state == EXEC)
        rsp_result <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed checks of arbitration, timing,
// backpressure and reset for alu_share_ctrl.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_func, req1_func;
  logic        req0_control, req1_control;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_func;
  logic        alu_control;
  logic        rsp_valid, rsp_id, rsp_ready;
  logic [31:0] rsp_result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Cycle counter for accept spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in combinational ALU.
  always_comb begin
    alu_result = '0;
    case (alu_func)
      3'b000: alu_result = alu_a + alu_b;
      3'b001: alu_result = alu_a << alu_b[4:0];
      3'b100: alu_result = alu_a ^ alu_b;
      3'b101: alu_result = alu_control ?
                $unsigned($signed(alu_a) >>> alu_b[4:0]) :
                alu_a >> alu_b[4:0];
      3'b110: alu_result = alu_a | alu_b;
      3'b111: alu_result = alu_a & alu_b;
      default: alu_result = '0;
    endcase
  end

  alu_share_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req0_func(req0_func), .req0_control(req0_control),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b),
    .req1_func(req1_func), .req1_control(req1_control),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_func(alu_func), .alu_control(alu_control),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_ready(rsp_ready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; leave time at edge+1 for driving inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_acc, n_rsp, last_acc, port;
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req0_func = 0; req0_control = 0;
    req1_a = 0; req1_b = 0; req1_func = 0; req1_control = 0;
    step(); step();
    #1;
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_func", {29'd0, alu_func}, 0);
    chk("rst_alu_ctl", {31'd0, alu_control}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 0);
    chk("rst_rsp_result", rsp_result, 0);
    req0_valid = 1;
    #1;
    chk("rst_ready0", {31'd0, req0_ready}, 0);
    chk("rst_ready1", {31'd0, req1_ready}, 0);
    req0_valid = 0;

    // Single ADD from port 0.
    step();
    rst = 0;
    req0_valid = 1; req0_a = 32'h1; req0_b = 32'h1;
    req0_func = 3'b000; req0_control = 0;
    #1;
    chk("add_ready0", {31'd0, req0_ready}, 1);
    chk("add_ready1", {31'd0, req1_ready}, 0);
    step();
    req0_valid = 0; rsp_ready = 1;
    #1;
    chk("add_alu_a", alu_a, 1);
    chk("add_alu_b", alu_b, 1);
    chk("add_exec_rv", {31'd0, rsp_valid}, 0);
    step(); #1;
    chk("add_rsp_valid", {31'd0, rsp_valid}, 1);
    chk("add_rsp_id", {31'd0, rsp_id}, 0);
    chk("add_rsp_result", rsp_result, 32'h2);
    step(); #1;
    chk("add_idle_rv", {31'd0, rsp_valid}, 0);

    // Wrap from port 1.
    req1_valid = 1; req1_a = 32'hFFFFFFFF; req1_b = 32'h1;
    req1_func = 3'b000; req1_control = 0;
    #1;
    chk("wrap_ready1", {31'd0, req1_ready}, 1);
    step();
    req1_valid = 0;
    step(); #1;
    chk("wrap_rsp_valid", {31'd0, rsp_valid}, 1);
    chk("wrap_rsp_id", {31'd0, rsp_id}, 1);
    chk("wrap_rsp_result", rsp_result, 32'h0);
    step();

    // Arithmetic shift right from port 0.
    req0_valid = 1; req0_a = 32'hFFFFFFF0; req0_b = 32'h4;
    req0_func = 3'b101; req0_control = 1;
    #1;
    chk("sra_ready0", {31'd0, req0_ready}, 1);
    step();
    req0_valid = 0;
    #1;
    chk("sra_alu_ctl", {31'd0, alu_control}, 1);
    chk("sra_alu_func", {29'd0, alu_func}, 32'h5);
    step(); #1;
    chk("sra_rsp_result", rsp_result, 32'hFFFFFFFF);
    chk("sra_rsp_id", {31'd0, rsp_id}, 0);
    step();

    // Contention from reset: expect 0,1,0,1 spaced 3 cycles.
    rst = 1;
    req0_valid = 1; req0_a = 32'hAAAAAAAA; req0_b = 32'h55555555;
    req0_func = 3'b100; req0_control = 0;
    req1_valid = 1; req1_a = 32'h0000FF00; req1_b = 32'h00FF0000;
    req1_func = 3'b111; req1_control = 0;
    rsp_ready = 1;
    step();
    rst = 0;
    n_acc = 0; n_rsp = 0; last_acc = 0;
    for (int i = 0; i < 40 && n_rsp < 4; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        chk("cont_grant", {31'd0, req1_ready}, n_acc % 2);
        chk("cont_onehot", {31'd0, req0_ready & req1_ready}, 0);
        if (n_acc > 0)
          chk("cont_spacing", cyc - last_acc, 3);
        last_acc = cyc;
        n_acc++;
      end
      if (rsp_valid) begin
        port = n_rsp % 2;
        chk("cont_rsp_id", {31'd0, rsp_id}, port);
        chk("cont_rsp_result", rsp_result,
            port == 0 ? 32'hFFFFFFFF : 32'h0);
        n_rsp++;
        if (n_rsp == 4) begin
          req0_valid = 0; req1_valid = 0;
        end
      end
      step();
    end
    chk("cont_rsp_count", n_rsp, 4);

    // Backpressure in RESP.
    rsp_ready = 0;
    req0_valid = 1; req0_a = 32'h5; req0_b = 32'h3;
    req0_func = 3'b000; req0_control = 0;
    #1;
    chk("bp_ready0", {31'd0, req0_ready}, 1);
    step();
    req1_valid = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 1);
      chk("bp_rsp_result", rsp_result, 32'h8);
      chk("bp_rsp_id", {31'd0, rsp_id}, 0);
      chk("bp_readies", {30'd0, req1_ready, req0_ready}, 0);
      step();
    end
    rsp_ready = 1;
    step(); #1;
    chk("bp_idle_rv", {31'd0, rsp_valid}, 0);
    chk("bp_new_ready1", {31'd0, req1_ready}, 1);
    chk("bp_new_ready0", {31'd0, req0_ready}, 0);
    step();
    req0_valid = 0; req1_valid = 0;
    #1;
    chk("bp_exec_alu_a", alu_a, 32'h0000FF00);

    // Reset during EXEC drops the op.
    rst = 1;
    step(); #1;
    rst = 0;
    chk("rmid_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rmid_alu_a", alu_a, 0);
    chk("rmid_alu_b", alu_b, 0);
    chk("rmid_alu_func", {29'd0, alu_func}, 0);
    chk("rmid_alu_ctl", {31'd0, alu_control}, 0);
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      chk("rmid_no_rsp", {31'd0, rsp_valid}, 0);
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("rmid_tie_port0", {30'd0, req1_ready, req0_ready}, 1);
    step();
    req0_valid = 0; req1_valid = 0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
